// File: rtl/lsu_pkg.sv
// Shared encodings for the mem_lsu load/store unit.
// Access sizes, FSM states and the misalignment predicate.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_R = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    MRG  = 3'd3,
    WR   = 3'd4,
    RESP = 3'd5
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SZ_H && off[0])
        || (size == SZ_W && off != 2'b00)
        || (size == SZ_R);
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake and data-memory port of mem_lsu.
// slave = LSU side, master = execute/writeback/memory side.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_data, resp_err,
    input  resp_ready,
    output dm_we, dm_addr, dm_din,
    input  dm_dout
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_data, resp_err,
    output resp_ready,
    input  dm_we, dm_addr, dm_din,
    output dm_dout
  );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: load extract/extend and store merge.
// Size 11 behaves as word; halves use off[1] only.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] mdata_o
);

  logic [4:0]  bsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {off_i, 3'b000};
  assign b   = rdata_i[bsh +: 8];
  assign h   = off_i[1] ? rdata_i[31:16]
                        : rdata_i[15:0];

  always_comb begin
    ldata_o = rdata_i;
    mdata_o = wdata_i;
    unique case (1'b1)
      (size_i == SZ_B): begin
        ldata_o = {{24{~uns_i & b[7]}}, b};
        mdata_o = rdata_i;
        mdata_o[bsh +: 8] = wdata_i[7:0];
      end
      (size_i == SZ_H): begin
        ldata_o = {{16{~uns_i & h[15]}}, h};
        mdata_o = rdata_i;
        if (off_i[1])
          mdata_o[31:16] = wdata_i[15:0];
        else
          mdata_o[15:0] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of the word-addressed data memory.
// Optional trap on misaligned/reserved access: LSU_MISALIGN_TRAP_EN.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic clk,
  input  logic clr_n,
  mem_lsu_if.slave bus
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              acc;
  logic [31:0]       ldata;
  logic [31:0]       mdata;
  logic              unused_hi;

  assign unused_hi = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  lsu_lane u_lane (
    .size_i  (size_q),
    .off_i   (off_q),
    .uns_i   (uns_q),
    .rdata_i (bus.dm_dout),
    .wdata_i (wdata_q),
    .ldata_o (ldata),
    .mdata_o (mdata)
  );

  always_comb begin
    state_d        = state_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    acc            = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_din     = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          acc     = 1'b1;
          rdata_d = '0;
          err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned(bus.req_size,
                         bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else
`endif
          if (bus.req_we && bus.req_size[1])
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: state_d = we_q ? MRG : CAP;
      CAP: begin
        rdata_d = ldata;
        state_d = RESP;
      end
      MRG: begin
        bus.dm_we  = 1'b1;
        bus.dm_din = mdata;
        state_d    = RESP;
      end
      WR: begin
        bus.dm_we  = 1'b1;
        bus.dm_din = wdata_q;
        state_d    = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (acc) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        off_q   <= bus.req_addr[1:0];
        idx_q   <= bus.req_addr[ADDR_W+1:2];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.dm_addr   = {{(32-ADDR_W){1'b0}}, idx_q};
  assign bus.resp_data = rdata_q;
  assign bus.resp_err  = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, reset abort, and
// random traffic against a byte-array memory model.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  mem_lsu_if bus();

  mem_lsu #(.ADDR_W(24)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:63] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.dm_we)
      mem[bus.dm_addr[5:0]] <= bus.dm_din;
    bus.dm_dout <= mem[bus.dm_addr[5:0]];
  end

  int we_cnt = 0;
  always @(negedge clk)
    if (bus.dm_we === 1'b1) we_cnt++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // byte-addressed reference memory (256 bytes)
  logic [7:0] rmem [0:255] = '{default: 8'h0};

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input logic [1:0] s,
                                 input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (s == 2'd3) || ((a % nbytes(s)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_base(input logic [1:0] s,
                                  input logic [31:0] a);
    int n = nbytes(s);
    return (int'(a & 32'hFF) / n) * n;
  endfunction

  function automatic logic [31:0] ref_load(
      input logic [1:0] s, input bit u,
      input logic [31:0] a);
    int n = nbytes(s);
    int bs = ref_base(s, a);
    logic [31:0] v = 0;
    logic [31:0] m;
    for (int i = 0; i < n; i++)
      v |= 32'(rmem[bs+i]) << (8 * i);
    if (n < 4) begin
      m = (32'd1 << (8 * n)) - 1;
      if (!u && v[8*n-1]) v |= ~m;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] s,
                           input logic [31:0] a,
                           input logic [31:0] d);
    int n = nbytes(s);
    int bs = ref_base(s, a);
    for (int i = 0; i < n; i++)
      rmem[bs+i] = 8'(d >> (8 * i));
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rmem[4*w+3], rmem[4*w+2],
            rmem[4*w+1], rmem[4*w]};
  endfunction

  // one complete transaction; starts #1 after a posedge
  task automatic do_op(input string nm,
                       input bit we, input logic [1:0] sz,
                       input bit u, input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] ed, input bit ee,
                       input int el, input logic [31:0] ei,
                       input int hold, input bit early);
    int lat;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    we_cnt = 0;
    chk({nm, ".rdy"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (early) bus.resp_ready = 1'b1;
    lat = 1;
    chk({nm, ".idx"}, bus.dm_addr, ei);
    chk({nm, ".busy"}, 32'(bus.req_ready), 32'd0);
    while (bus.resp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".lat"}, 32'(lat), 32'(el));
    chk({nm, ".data"}, bus.resp_data, ed);
    chk({nm, ".err"}, 32'(bus.resp_err), 32'(ee));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({nm, ".hv"}, 32'(bus.resp_valid), 32'd1);
        chk({nm, ".hd"}, bus.resp_data, ed);
        chk({nm, ".hr"}, 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({nm, ".done"}, 32'(bus.resp_valid), 32'd0);
    chk({nm, ".idle"}, 32'(bus.req_ready), 32'd1);
    chk({nm, ".wecnt"}, 32'(we_cnt),
        32'(we && !ee));
    if (we && !ee) begin
      ref_store(sz, a, wd);
      chk({nm, ".mem"}, mem[ei[5:0]],
          ref_word(int'(ei[5:0])));
    end
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ed;
    bit          ee;
    int          el;
    int          hold;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
      input bit we, input logic [1:0] sz, input bit u,
      input logic [31:0] a, input logic [31:0] wd,
      input logic [31:0] ed, input bit ee,
      input int el, input int hold);
    vec_t v;
    v.we = we; v.sz = sz; v.u = u; v.a = a;
    v.wd = wd; v.ed = ed; v.ee = ee;
    v.el = el; v.hold = hold;
    return v;
  endfunction

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;

    #1 clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rv", 32'(bus.resp_valid), 32'd0);
    chk("rst.rd", bus.resp_data, 32'd0);
    chk("rst.re", 32'(bus.resp_err), 32'd0);
    chk("rst.we", 32'(bus.dm_we), 32'd0);
    chk("rst.da", bus.dm_addr, 32'd0);
    chk("rst.dd", bus.dm_din, 32'd0);
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.rdy", 32'(bus.req_ready), 32'd1);

    tbl.push_back(mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 0));
    tbl.push_back(mk(0, 2, 0, 32'h10, 0, 32'hDEADBEEF, 0, 3, 4));
    tbl.push_back(mk(1, 2, 0, 32'h10, 32'h11223344, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 32'h11, 32'h123456AA, 0, 0, 3, 1));
    tbl.push_back(mk(0, 2, 0, 32'h10, 0, 32'h1122AA44, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 32'h11, 0, 32'hFFFFFFAA, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 32'h11, 0, 32'h000000AA, 0, 3, 2));
    tbl.push_back(mk(1, 2, 0, 32'h20, 32'h8001ABCD, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 32'h22, 0, 32'hFFFF8001, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 32'h22, 0, 32'h00008001, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, 32'h20, 32'hFFFF5555, 0, 0, 3, 0));
    tbl.push_back(mk(0, 2, 0, 32'h20, 0, 32'h80015555, 0, 3, 0));
    tbl.push_back(mk(0, 2, 0, 32'h80000020, 0, 32'h80015555, 0, 3, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 1, 0, 32'h23, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 3, 0, 32'h20, 0, 0, 1, 1, 2));
    tbl.push_back(mk(1, 2, 0, 32'h21, 32'h0BADF00D, 0, 1, 1, 0));
`else
    tbl.push_back(mk(0, 1, 0, 32'h23, 0, 32'hFFFF8001, 0, 3, 0));
    tbl.push_back(mk(0, 3, 0, 32'h20, 0, 32'h80015555, 0, 3, 2));
    tbl.push_back(mk(1, 2, 0, 32'h21, 32'h0BADF00D, 0, 0, 2, 0));
`endif
    tbl.push_back(mk(0, 2, 0, 32'h20, 0,
`ifdef LSU_MISALIGN_TRAP_EN
                     32'h80015555,
`else
                     32'h0BADF00D,
`endif
                     0, 3, 0));

    foreach (tbl[i])
      do_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz,
            tbl[i].u, tbl[i].a, tbl[i].wd, tbl[i].ed,
            tbl[i].ee, tbl[i].el,
            (tbl[i].a & 32'h03FFFFFF) >> 2,
            tbl[i].hold, 1'b0);

    // abort a byte store while it sits in the merge cycle
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd0;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h77;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort.mrg", 32'(bus.dm_we), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("abort.we", 32'(bus.dm_we), 32'd0);
    chk("abort.rv", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    #1;
    chk("abort.rdy", 32'(bus.req_ready), 32'd1);
    chk("abort.mem", mem[4], ref_word(4));
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      bit we, u, ee, early;
      logic [1:0] sz;
      logic [31:0] a, wd, ed;
      int el;
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom & 32'hFC000000)
         | 32'($urandom_range(0, 255));
      wd = $urandom;
      ee = ref_err(sz, a);
      ed = (we || ee) ? 32'd0 : ref_load(sz, u, a);
      el = ee ? 1 : (we && sz[1]) ? 2 : 3;
      early = ($urandom_range(0, 3) == 0);
      do_op($sformatf("rnd%0d", k), we, sz, u, a, wd,
            ed, ee, el, (a & 32'h03FFFFFF) >> 2,
            $urandom_range(0, 2), early);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit directly upstream of the word-addressed data memory in cpuX.
- Accepts byte/halfword/word load and store requests from the execute stage over a valid/ready handshake.
- Drives the data memory's port: registered read, write-on-clock-edge, word index. Sub-word stores are done as read-modify-write.
- Returns aligned, sign/zero-extended load data to writeback through a valid/ready response.

Parameters:
- ADDR_W, 24, width of the memory word index; dm_addr = zero-extended req_addr[ADDR_W+1:2].

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where valid&ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed on an edge where valid&ready
- resp_data  out  32  load result; 0 for stores
- resp_err  out  1  misaligned/reserved flag (only with macro, else 0)
- dm_we  out  1  memory write enable
- dm_addr  out  32  memory word index
- dm_din  out  32  memory write data
- dm_dout  in  32  memory registered read data, valid the cycle after the address is presented

Behaviour:
- Reset (clr_n low, async):
  - state=IDLE; resp_valid=0, resp_data=0, resp_err=0, dm_we=0, dm_addr=0, dm_din=0.
  - Any in-flight operation is abandoned. A write whose edge has not occurred is not performed.
- Little-endian lanes:
  - byte k = bits 8k+7:8k with k=addr[1:0].
  - half h = bits 16h+15:16h with h=addr[1].
- States:
  - IDLE: req_ready=1. On accept, latch the request. Word store -> WR; load -> RD; sub-word store -> RD.
  - RD: dm_addr=latched index, dm_we=0. Next state: CAP for a load, MRG for a store.
  - CAP: dm_dout valid; extract lane, extend; register resp_data -> RESP.
  - MRG: dm_we=1; dm_din = dm_dout with the selected lane replaced by req_wdata[7:0] or [15:0] -> RESP.
  - WR: dm_we=1, dm_din=req_wdata -> RESP.
  - RESP: resp_valid=1; hold resp_data/resp_err stable until resp_ready; then IDLE.
- req_ready=0 in every state but IDLE. No back-to-back accept: at most one op in flight.
- dm_we is decoded from state only, never asserted outside WR/MRG. dm_addr holds the latched index in all non-IDLE states.
- Latency, measured as the edge at which resp_valid rises after the accept edge:
  - word store: 2 edges
  - load: 3 edges
  - sub-word store: 3 edges
- resp_ready may be high on arrival; RESP lasts at least one cycle.
- Size 11 is treated as word.
- Address bits above ADDR_W+1 are ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- With the macro:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size 11 goes IDLE -> RESP directly.
  - resp_err=1, resp_data=0, no memory access, dm_we stays 0.
- Without the macro:
  - Offending low address bits are ignored: half uses addr[1] only, word ignores addr[1:0].
  - resp_err is tied 0.

Decomposition:
- Package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), state encoding (IDLE, RD, CAP, MRG, WR, RESP).
- Sub-module lsu_lane, purely combinational: load extract/extend and store merge, given size, addr[1:0], unsigned flag.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> dm_addr=4, dm_we one cycle; resp_data=0xDEADBEEF three edges after the load accept.
- Byte store 0xAA @0x11 over 0x11223344 -> MRG writes 0x1122AA44; then signed byte load @0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Half load @0x12 of 0x8001ABCD, signed -> 0xFFFF8001; half store 0x5555 @0x10 -> 0x80015555.
- resp_ready held low 4 cycles -> resp_valid/resp_data stable, req_ready=0 throughout; accept resumes the cycle after the handshake.
- clr_n pulsed low in MRG -> dm_we drops immediately, word unchanged, resp_valid=0, req_ready=1 after release.
- Half load @0x13 -> macro on: resp_err=1, no dm_we, 1-edge response; macro off: lane addr[1]=1 returned, resp_err=0.
